// File: rtl/uart_ring_fifo.sv
// Ring buffer between the UART RX/TX engines and the CPU-side bus.
// Count-tracked occupancy, req/ack read port, sticky overflow flag.
module uart_ring_fifo #(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 14
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         dataWriteEnable,
    input  logic [DATA_WIDTH-1:0]        dataWrite,
    input  logic                         dataReadEnable,
    output logic                         dataReadAck,
    output logic [DATA_WIDTH-1:0]        dataRead,
    input  logic                         clearOverflow,
    output logic                         full,
    output logic                         empty,
    output logic                         almostFull,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(ALMOST_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  drop;

    // Status flags are pure decodes of the occupancy register
    always_comb begin
        full       = (count == CNT_FULL);
        empty      = (count == '0);
        almostFull = (count >= CNT_AF);
    end

    // A read frees a slot on the same edge, so a full buffer still takes a write
    always_comb begin
        rd_ok = dataReadEnable & ~empty;
        wr_ok = dataWriteEnable & (~full | rd_ok);
        drop  = dataWriteEnable & ~wr_ok;
    end

    // Storage is left unreset; stale contents are unreachable after reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= dataWrite;
        end
    end

    // Pointers wrap by natural overflow of their PW-bit width
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel out
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read port: ack pulses one cycle, data holds until the next pop
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dataReadAck <= 1'b0;
            dataRead    <= '0;
        end else begin
            dataReadAck <= rd_ok;
            if (rd_ok) begin
                dataRead <= mem[rd_ptr];
            end
        end
    end

    // Sticky overflow; a drop on the same edge beats a clear
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clearOverflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ring_fifo.sv
// Randomized and directed bench for uart_ring_fifo.
// Reference model is a plain queue with an occupancy limit.
module tb_uart_ring_fifo;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AFL = 14;
    localparam int CW  = $clog2(DEP + 1);

    logic          clk;
    logic          resetN;
    logic          dataWriteEnable;
    logic [DW-1:0] dataWrite;
    logic          dataReadEnable;
    logic          dataReadAck;
    logic [DW-1:0] dataRead;
    logic          clearOverflow;
    logic          full;
    logic          empty;
    logic          almostFull;
    logic [CW-1:0] count;
    logic          overflow;

    uart_ring_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEP),
        .ALMOST_FULL_LEVEL(AFL)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .dataWriteEnable(dataWriteEnable),
        .dataWrite(dataWrite),
        .dataReadEnable(dataReadEnable),
        .dataReadAck(dataReadAck),
        .dataRead(dataRead),
        .clearOverflow(clearOverflow),
        .full(full),
        .empty(empty),
        .almostFull(almostFull),
        .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_data;
    logic          m_ack;
    logic          m_ovf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_data = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ack"}, dataReadAck, m_ack);
        chk({tag, "_data"}, dataRead, m_data);
        chk({tag, "_cnt"}, count, q.size());
        chk({tag, "_full"}, full, q.size() == DEP);
        chk({tag, "_empty"}, empty, q.size() == 0);
        chk({tag, "_af"}, almostFull, q.size() >= AFL);
        chk({tag, "_ovf"}, overflow, m_ovf);
    endtask

    // one clock: drive, edge, update model from pre-edge state, compare
    task automatic cyc(input logic wen, input logic [DW-1:0] wd,
                       input logic ren, input logic clr,
                       input string tag);
        bit rd, wr;
        dataWriteEnable = wen;
        dataWrite       = wd;
        dataReadEnable  = ren;
        clearOverflow   = clr;
        rd = ren && (q.size() > 0);
        wr = wen && ((q.size() < DEP) || rd);
        @(posedge clk);
        #1;
        m_ack = rd;
        if (rd) m_data = q.pop_front();
        if (wr) q.push_back(wd);
        if (wen && !wr) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        check_all(tag);
    endtask

    task automatic fill(input int base, input string tag);
        for (int i = 0; i < DEP; i++) cyc(1, DW'(base + i), 0, 0, tag);
    endtask

    initial begin
        resetN          = 1'b0;
        dataWriteEnable = 1'b0;
        dataWrite       = '0;
        dataReadEnable  = 1'b0;
        clearOverflow   = 1'b0;
        model_reset();
        #12;
        check_all("rst");
        @(negedge clk);
        resetN = 1'b1;

        // T1: reset mid-stream, then read an empty buffer
        for (int i = 0; i < 5; i++) cyc(1, DW'(8'hC0 + i), 0, 0, "t1w");
        cyc(0, 0, 1, 0, "t1r");
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        check_all("t1rst");
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, "t1e");
            chk("t1_ack0", dataReadAck, 0);
            chk("t1_data0", dataRead, 0);
            chk("t1_cnt0", count, 0);
        end

        // T2: ordering, status flags, pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEP; i++) begin
                cyc(1, DW'(pass * 16 + i + 1), 0, 0, "t2w");
                chk("t2_af", almostFull, (i + 1) >= AFL);
            end
            chk("t2_full", full, 1);
            for (int i = 0; i < DEP; i++) begin
                cyc(0, 0, 1, 0, "t2r");
                chk("t2_ack", dataReadAck, 1);
                chk("t2_ord", dataRead, pass * 16 + i + 1);
            end
            chk("t2_empty", empty, 1);
        end

        // T3: overflow drop and clear, with clear-vs-drop priority
        fill(1, "t3f");
        cyc(1, 8'hAA, 0, 0, "t3o");
        chk("t3_cnt", count, 16);
        chk("t3_ovf", overflow, 1);
        cyc(1, 8'hAB, 0, 1, "t3pri");
        chk("t3_pri", overflow, 1);
        cyc(0, 0, 1, 0, "t3r");
        chk("t3_old", dataRead, 8'h01);
        cyc(0, 0, 0, 1, "t3c");
        chk("t3_clr", overflow, 0);
        for (int i = 0; i < DEP - 1; i++) cyc(0, 0, 1, 0, "t3d");

        // T4: simultaneous read+write at full
        fill(1, "t4f");
        cyc(1, 8'h55, 1, 0, "t4s");
        chk("t4_ack", dataReadAck, 1);
        chk("t4_data", dataRead, 8'h01);
        chk("t4_cnt", count, 16);
        chk("t4_ovf", overflow, 0);
        for (int i = 0; i < DEP; i++) cyc(0, 0, 1, 0, "t4d");
        chk("t4_last", dataRead, 8'h55);

        // T5: simultaneous read+write at empty
        cyc(1, 8'h77, 1, 0, "t5s");
        chk("t5_ack", dataReadAck, 0);
        chk("t5_cnt", count, 1);
        cyc(0, 0, 1, 0, "t5r");
        chk("t5_ack1", dataReadAck, 1);
        chk("t5_data", dataRead, 8'h77);

        // random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 55), DW'($urandom),
                ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 99) < 5), "rnd");
        end
        while (q.size() > 0) cyc(0, 0, 1, 0, "rdr");

        // T6: asynchronous reset between edges at count 9
        for (int i = 0; i < 10; i++) cyc(1, DW'(i), 0, 0, "t6w");
        cyc(0, 0, 1, 0, "t6r");
        chk("t6_pre", count, 9);
        #2;
        resetN = 1'b0;
        model_reset();
        #1;
        chk("t6_cnt", count, 0);
        chk("t6_ack", dataReadAck, 0);
        chk("t6_empty", empty, 1);
        @(negedge clk);
        resetN = 1'b1;
        cyc(0, 0, 0, 0, "t6i");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
